// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the controller and target datapaths.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned I2C_CNT_W  = 3;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT
    } i2c_tgt_state_t;

    // General call (0x00) and the 10-bit prefix (11110xx) never match.
    function automatic logic i2c_addr_match(input logic [I2C_ADDR_W-1:0] addr,
                                            input logic [I2C_ADDR_W-1:0] own);
        return (addr == own) && (addr != '0) && (addr[6:2] != 5'b11110);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA and produces one-clk edge, START and STOP flags.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_q;
    logic                   sda_q;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Chains reset to the idle-high bus level so reset release creates no edges.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q     <= scl_s;
            sda_q     <= sda_s;
            scl_rise  <= scl_s & ~scl_q;
            scl_fall  <= ~scl_s & scl_q;
            start_det <= scl_s & scl_q & sda_q & ~sda_s;
            stop_det  <= scl_s & scl_q & ~sda_q & sda_s;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write-byte delivery and read-byte shifting.
// SDA is open-drain: sda_oe pulls the line low, otherwise it is released.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_nack,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_load,
    output logic                  addr_hit,
    output logic                  stop_det,
    output logic                  busy
);

    logic sda_s, scl_rise, scl_fall, start_p, stop_p;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .resetN   (resetN),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_p),
        .stop_det (stop_p)
    );

    i2c_tgt_state_t        state, state_nxt;
    logic [I2C_CNT_W-1:0]  cnt, cnt_nxt;
    logic [I2C_BYTE_W-1:0] shift, shift_nxt, shift_in;
    logic [I2C_BYTE_W-1:0] rx_data_nxt;
    logic phase, phase_nxt, rw, rw_nxt, nack_l, nack_nxt;
    logic sda_oe_nxt, rx_valid_nxt, tx_load_nxt, addr_hit_nxt, stop_det_nxt, busy_nxt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= ST_IDLE;
            cnt      <= '1;
            shift    <= '0;
            phase    <= 1'b0;
            rw       <= 1'b0;
            nack_l   <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            addr_hit <= 1'b0;
            stop_det <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shift    <= shift_nxt;
            phase    <= phase_nxt;
            rw       <= rw_nxt;
            nack_l   <= nack_nxt;
            sda_oe   <= sda_oe_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            tx_load  <= tx_load_nxt;
            addr_hit <= addr_hit_nxt;
            stop_det <= stop_det_nxt;
            busy     <= busy_nxt;
        end
    end

    // phase marks the second SCL fall of an ACK slot (or a master ACK seen in RD_ACK).
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shift_nxt    = shift;
        phase_nxt    = phase;
        rw_nxt       = rw;
        nack_nxt     = nack_l;
        sda_oe_nxt   = sda_oe;
        rx_data_nxt  = rx_data;
        busy_nxt     = busy;
        rx_valid_nxt = 1'b0;
        tx_load_nxt  = 1'b0;
        addr_hit_nxt = 1'b0;
        stop_det_nxt = 1'b0;
        shift_in     = {shift[I2C_BYTE_W-2:0], sda_s};

        if (stop_p) begin
            state_nxt    = ST_IDLE;
            sda_oe_nxt   = 1'b0;
            busy_nxt     = 1'b0;
            stop_det_nxt = 1'b1;
        end else if (start_p) begin
            state_nxt  = ST_ADDR;
            cnt_nxt    = '1;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: sda_oe_nxt = 1'b0;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_nxt = shift_in;
                        cnt_nxt   = cnt - 3'd1;
                        if (cnt == '0) begin
                            if (i2c_addr_match(shift_in[7:1], TARGET_ADDR)) begin
                                state_nxt    = ST_ADDR_ACK;
                                addr_hit_nxt = 1'b1;
                                busy_nxt     = 1'b1;
                                rw_nxt       = shift_in[0];
                                phase_nxt    = 1'b0;
                            end else begin
                                state_nxt = ST_WAIT;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_oe_nxt = 1'b1;
                            phase_nxt  = 1'b1;
                        end else if (rw == I2C_READ) begin
                            state_nxt   = ST_RD_DATA;
                            tx_load_nxt = 1'b1;
                            shift_nxt   = tx_data;
                            cnt_nxt     = '1;
                            sda_oe_nxt  = ~tx_data[I2C_BYTE_W-1];
                        end else begin
                            state_nxt  = ST_WR_DATA;
                            cnt_nxt    = '1;
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt = shift_in;
                        cnt_nxt   = cnt - 3'd1;
                        if (cnt == '0) begin
                            rx_data_nxt  = shift_in;
                            rx_valid_nxt = 1'b1;
                            nack_nxt     = rx_nack;
                            phase_nxt    = 1'b0;
                            state_nxt    = ST_WR_ACK;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_oe_nxt = (nack_l == I2C_ACK);
                            phase_nxt  = 1'b1;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            if (nack_l == I2C_NACK) begin
                                state_nxt = ST_WAIT;
                                busy_nxt  = 1'b0;
                            end else begin
                                state_nxt = ST_WR_DATA;
                                cnt_nxt   = '1;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt == '0) begin
                            sda_oe_nxt = 1'b0;
                            phase_nxt  = 1'b0;
                            state_nxt  = ST_RD_ACK;
                        end else begin
                            cnt_nxt    = cnt - 3'd1;
                            sda_oe_nxt = ~shift[cnt - 3'd1];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            state_nxt = ST_WAIT;
                            busy_nxt  = 1'b0;
                        end else begin
                            phase_nxt = 1'b1;
                        end
                    end else if (scl_fall && phase) begin
                        state_nxt   = ST_RD_DATA;
                        tx_load_nxt = 1'b1;
                        shift_nxt   = tx_data;
                        cnt_nxt     = '1;
                        sda_oe_nxt  = ~tx_data[I2C_BYTE_W-1];
                    end
                end
                ST_WAIT: begin
                    sda_oe_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level bus master plus a transaction-level model.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       resetN;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_nack;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       addr_hit;
    logic       stop_det;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt = 0, tx_cnt = 0, hit_cnt = 0, stop_cnt = 0, hold_viol = 0;
    logic       oe_prev = 1'b0;
    logic [7:0] rx_log [256];
    logic [7:0] txbuf  [256];
    logic [7:0] wdata  [4];
    logic       wnack  [4];

    always #5 clk = ~clk;

    assign scl_in  = scl_m;
    assign sda_in  = sda_m & ~sda_oe;
    assign tx_data = txbuf[tx_cnt % 256];

    i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetN(resetN), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid), .rx_nack(rx_nack),
        .tx_data(tx_data), .tx_load(tx_load), .addr_hit(addr_hit),
        .stop_det(stop_det), .busy(busy)
    );

    // Pulse logging and SDA-stability watch (no drive change while SCL is high).
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 256] = rx_data;
            rx_cnt++;
        end
        if (tx_load)  tx_cnt++;
        if (addr_hit) hit_cnt++;
        if (stop_det) stop_cnt++;
        if (resetN && scl_in && (sda_oe != oe_prev)) hold_viol++;
        oe_prev = sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic start_cond();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b = sda_in; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
    endtask

    // One transaction; expectations come from the protocol rules, not the RTL.
    task automatic xfer(input logic [7:0] ab, input int nb, input bit do_stop);
        bit         match = (ab[7:1] == 7'h50);
        bit         gone  = !match;
        int         rx0 = rx_cnt, tx0 = tx_cnt, hit0 = hit_cnt, st0 = stop_cnt;
        int         exp_rx = 0;
        logic       b;
        logic [7:0] byt;
        start_cond();
        send_byte(ab, b);
        check("addr_ack", 32'(b), match ? 32'd0 : 32'd1);
        check("addr_hit", 32'(hit_cnt - hit0), 32'(match));
        check("busy_after_addr", 32'(busy), 32'(match));
        if (ab[0] == 1'b0) begin
            for (int k = 0; k < nb; k++) begin
                rx_nack = wnack[k];
                send_byte(wdata[k], b);
                if (!gone) begin
                    check("wr_ack", 32'(b), 32'(wnack[k]));
                    exp_rx++;
                    check("rx_byte", 32'(rx_log[(rx0 + exp_rx - 1) % 256]), 32'(wdata[k]));
                    if (wnack[k]) gone = 1'b1;
                end else begin
                    check("wr_ignored", 32'(b), 32'd1);
                end
            end
            rx_nack = 1'b0;
            check("rx_count", 32'(rx_cnt - rx0), 32'(exp_rx));
        end else begin
            for (int k = 0; k < nb; k++) begin
                recv_byte(byt);
                check("rd_byte", 32'(byt), gone ? 32'hFF : 32'(txbuf[(tx0 + k) % 256]));
                send_bit((k == nb - 1) ? 1'b1 : 1'b0);
            end
            check("tx_loads", 32'(tx_cnt - tx0), match ? 32'(nb) : 32'd0);
            check("oe_after_nack", 32'(sda_oe), 32'd0);
            check("rx_none_on_read", 32'(rx_cnt - rx0), 32'd0);
        end
        if (do_stop) begin
            stop_cond();
            check("stop_det", 32'(stop_cnt - st0), 32'd1);
            check("busy_after_stop", 32'(busy), 32'd0);
            check("oe_after_stop", 32'(sda_oe), 32'd0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        logic [7:0] byt;
        logic [7:0] ab;
        int         nb;
        for (int i = 0; i < 256; i++) txbuf[i] = 8'h00;
        for (int i = 0; i < 256; i++) rx_log[i] = 8'h00;
        resetN = 1'b0; scl_m = 1'b1; sda_m = 1'b1; rx_nack = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_pulses", 32'({rx_valid, tx_load, addr_hit, stop_det}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Plain write of 0x3C.
        wdata[0] = 8'h3C; wnack[0] = 1'b0;
        xfer(8'hA0, 1, 1'b1);
        check("rx_data_hold", 32'(rx_data), 32'h3C);

        // Read 0xA5 (ACK) then 0x5A (NACK).
        txbuf[tx_cnt % 256] = 8'hA5; txbuf[(tx_cnt + 1) % 256] = 8'h5A;
        xfer(8'hA1, 2, 1'b1);

        // Mismatched address, data byte 0x11 must be ignored.
        wdata[0] = 8'h11; wnack[0] = 1'b0;
        xfer(8'hA2, 1, 1'b1);

        // Write 0x12, repeated START, read 0x77.
        wdata[0] = 8'h12; wnack[0] = 1'b0;
        xfer(8'hA0, 1, 1'b0);
        txbuf[tx_cnt % 256] = 8'h77;
        xfer(8'hA1, 1, 1'b1);
        check("rx_data_after_sr", 32'(rx_data), 32'h12);

        // Local NACK of 0xFF; following byte ignored.
        wdata[0] = 8'hFF; wnack[0] = 1'b1; wdata[1] = 8'h42; wnack[1] = 1'b0;
        xfer(8'hA0, 2, 1'b1);
        check("rx_data_after_nack", 32'(rx_data), 32'hFF);

        // Reset during the 4th bit of a read byte that drives SDA low.
        txbuf[tx_cnt % 256] = 8'h00;
        start_cond();
        send_byte(8'hA1, b);
        check("rst_addr_ack", 32'(b), 32'd0);
        for (int i = 0; i < 3; i++) recv_bit(b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        check("rst_pre_oe", 32'(sda_oe), 32'd1);
        @(posedge clk); #2;
        resetN = 1'b0;
        #1;
        check("rst_async_oe", 32'(sda_oe), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1 scl_m = 1'b1; sda_m = 1'b1;
        repeat (4) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wdata[0] = 8'h5C; wnack[0] = 1'b0;
        xfer(8'hA0, 1, 1'b1);

        // Randomized transactions.
        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 2) != 0) ab = {7'h50, 1'b0};
            else begin
                ab = 8'($urandom_range(0, 255));
                if (ab[7:1] == 7'h50) ab[7:1] = 7'h51;
            end
            ab[0] = 1'($urandom_range(0, 1));
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) begin
                wdata[k] = 8'($urandom_range(0, 255));
                wnack[k] = ($urandom_range(0, 3) == 0);
                txbuf[(tx_cnt + k) % 256] = 8'($urandom_range(0, 255));
            end
            xfer(ab, nb, 1'b1);
        end

        check("sda_hold_viol", 32'(hold_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
